// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory with a fixed read latency.
// Define ARB_RR_EN for round-robin conflict resolution; otherwise the core has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: READ_LATENCY must be in the range 1..15");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t             state_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic               owner_q;      // 0 = core, 1 = loader
  logic [DATA_W-1:0]  c_rdata_q;
  logic [DATA_W-1:0]  l_rdata_q;

  logic               grant;
  logic               pick_l;
  logic               win_we;
  logic               rd_done;

`ifdef ARB_RR_EN
  logic               last_winner_q; // 0 = core, 1 = loader
`endif

  always_comb begin
    grant = (state_q == IDLE) && !reset && (c_req || l_req);
`ifdef ARB_RR_EN
    // On a conflict the port that did not win the previous grant goes first.
    pick_l = l_req && (!c_req || !last_winner_q);
`else
    pick_l = !c_req;
`endif
    win_we = pick_l ? l_we : c_we;
  end

  assign c_gnt     = grant && !pick_l;
  assign l_gnt     = grant && pick_l;
  assign mem_en    = grant;
  assign mem_we    = grant && win_we;
  assign mem_addr  = grant ? (pick_l ? l_addr : c_addr) : '0;
  assign mem_wdata = grant ? (pick_l ? l_wdata : c_wdata) : '0;

  // Read data is returned in the same cycle the memory presents it, then held.
  assign rd_done  = (state_q == RD_WAIT) && (lat_cnt_q == LAT_W'(1)) && !reset;
  assign c_rvalid = rd_done && !owner_q;
  assign l_rvalid = rd_done && owner_q;
  assign c_rdata  = c_rvalid ? mem_rdata : c_rdata_q;
  assign l_rdata  = l_rvalid ? mem_rdata : l_rdata_q;
  assign busy     = (state_q == RD_WAIT) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      owner_q   <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant && !win_we) begin
            owner_q   <= pick_l;
            lat_cnt_q <= LAT_W'(READ_LATENCY);
            state_q   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          if (lat_cnt_q == LAT_W'(1)) begin
            state_q <= IDLE;
            if (owner_q) begin
              l_rdata_q <= mem_rdata;
            end else begin
              c_rdata_q <= mem_rdata;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= 1'b1;
    end else if (grant) begin
      last_winner_q <= pick_l;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference of the arbitration and read-return rules.
module tb_mem_arbiter;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [31:0] c_rdata, l_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] seed(int idx);
    return (idx == 4) ? 32'hDEADBEEF : 32'h5A00_0000 + 32'(idx) * 32'h0001_0101;
  endfunction

  // Memory macro: RL-cycle read pipeline, junk on the bus when nothing is due.
  logic [31:0] mem [64];
  logic        wr  [64];
  logic [31:0] pd  [1:RL];
  logic        pv  [1:RL];
  logic [31:0] junk;
  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_en && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr[mem_addr[7:2]]  <= 1'b1;
    end
    pv[1] <= mem_en && !mem_we;
    pd[1] <= (wr[mem_addr[7:2]] === 1'b1) ? mem[mem_addr[7:2]] : seed(int'(mem_addr[7:2]));
    for (int k = 2; k <= RL; k++) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
  end
  assign mem_rdata = (pv[RL] === 1'b1) ? pd[RL] : junk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  req_t cq[$];
  req_t lq[$];

  // Reference state: expressed as cycle numbers rather than a counter.
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  int          rv_cyc = 0;
  bit          pend = 0;
  bit          rv_port = 0;
  logic [31:0] rv_data = '0;
  bit          last_w = 1;
  logic [31:0] hold_c = '0;
  logic [31:0] hold_l = '0;
  logic [31:0] ref_mem [64];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(bit rst);
    req_t rc, rl;
    bit g, pl, we, evc, evl, eb;
    logic [31:0] a, d;
    @(negedge clk);
    reset = rst;
    if (cq.size() > 0) rc = cq[0]; else rc = {1'($urandom), 32'($urandom), 32'($urandom)};
    if (lq.size() > 0) rl = lq[0]; else rl = {1'($urandom), 32'($urandom), 32'($urandom)};
    c_req = (cq.size() > 0); c_we = rc.we; c_addr = rc.addr; c_wdata = rc.wdata;
    l_req = (lq.size() > 0); l_we = rl.we; l_addr = rl.addr; l_wdata = rl.wdata;
    #1;
    g = !rst && (cyc >= free_cyc) && (c_req || l_req);
    if (c_req && l_req) begin
`ifdef ARB_RR_EN
      pl = (last_w == 1'b0);
`else
      pl = 1'b0;
`endif
    end else begin
      pl = l_req;
    end
    we  = pl ? rl.we : rc.we;
    a   = pl ? rl.addr : rc.addr;
    d   = pl ? rl.wdata : rc.wdata;
    evc = !rst && pend && (rv_cyc == cyc) && !rv_port;
    evl = !rst && pend && (rv_cyc == cyc) && rv_port;
    eb  = !rst && pend && (cyc <= rv_cyc);
    chk("c_gnt", 32'(c_gnt), 32'(g && !pl));
    chk("l_gnt", 32'(l_gnt), 32'(g && pl));
    chk("mem_en", 32'(mem_en), 32'(g));
    chk("mem_we", 32'(mem_we), 32'(g && we));
    chk("mem_addr", mem_addr, g ? a : 32'h0);
    chk("mem_wdata", mem_wdata, g ? d : 32'h0);
    chk("c_rvalid", 32'(c_rvalid), 32'(evc));
    chk("l_rvalid", 32'(l_rvalid), 32'(evl));
    chk("c_rdata", c_rdata, evc ? rv_data : hold_c);
    chk("l_rdata", l_rdata, evl ? rv_data : hold_l);
    chk("busy", 32'(busy), 32'(eb));
    if (g) $display("txn cyc=%0d grant=%s we=%0b addr=%h wdata=%h", cyc, pl ? "loader" : "core", we, a, d);
    if (evc || evl) $display("txn cyc=%0d rvalid=%s rdata=%h", cyc, evl ? "loader" : "core", rv_data);
    @(posedge clk);
    if (rst) begin
      pend = 0; free_cyc = cyc + 1; last_w = 1; hold_c = '0; hold_l = '0;
    end else begin
      if (evc) hold_c = rv_data;
      if (evl) hold_l = rv_data;
      if (evc || evl) pend = 0;
      if (g) begin
        last_w = pl;
        if (pl) void'(lq.pop_front()); else void'(cq.pop_front());
        if (we) begin
          ref_mem[a[7:2]] = d;
        end else begin
          pend = 1; rv_cyc = cyc + RL; rv_port = pl; rv_data = ref_mem[a[7:2]];
          free_cyc = cyc + RL + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic drain(string tag, int max_cyc);
    int n = 0;
    while ((cq.size() > 0 || lq.size() > 0 || pend) && n < max_cyc) begin
      step(0);
      n++;
    end
    step(0);
    chk({tag, "_done"}, 32'(cq.size() + lq.size() + int'(pend)), 32'h0);
  endtask

  function automatic req_t mk(bit we, int idx, logic [31:0] wd);
    return {we, 32'(idx) << 2, wd};
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    @(posedge clk);

    // Reset held with both requesters waiting, then the core read of 0x10 completes.
    cq.push_back(mk(0, 4, '0));
    lq.push_back(mk(0, 8, '0));
    step(1);
    step(1);
    drain("reset_and_core_read", 40);

    // Loader writes 1..4 back-to-back, core reads 0x8.
    for (int i = 0; i < 4; i++) lq.push_back(mk(1, i, 32'(i + 1)));
    drain("loader_writes", 20);
    cq.push_back(mk(0, 2, '0));
    drain("core_read_back", 20);

    // Persistent read conflict.
    for (int i = 0; i < 8; i++) begin
      cq.push_back(mk(0, 16 + i, '0));
      lq.push_back(mk(0, 32 + i, '0));
    end
    drain("conflict", 100);

    // Core write arrives while a loader read is outstanding.
    lq.push_back(mk(0, 3, '0));
    step(0);
    cq.push_back(mk(1, 5, 32'hC0FFEE00));
    drain("write_in_rdwait", 20);

    // Reset during RD_WAIT abandons the read; a fresh read then completes.
    cq.push_back(mk(0, 12, '0));
    step(0);
    step(1);
    cq.push_back(mk(0, 12, '0));
    drain("reset_in_rdwait", 20);

    // Random traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (cq.size() == 0 && $urandom_range(2) == 0)
        cq.push_back(mk(1'($urandom), int'($urandom_range(63)), 32'($urandom)));
      if (lq.size() == 0 && $urandom_range(2) == 0)
        lq.push_back(mk(1'($urandom), int'($urandom_range(63)), 32'($urandom)));
      step($urandom_range(79) == 0);
    end
    drain("random", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
